// File: rtl/mem_writer_if.sv
// Request/response bundle between a requester and mem_writer.
// The requester drives the request fields; mem_writer drives the memory, register and stack write ports.
interface mem_writer_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  write_req;
    logic [2:0]            write_mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  data;
    logic [ADDR_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0]  status;
    logic [REG_WIDTH-1:0]  sp;
    logic [3:0]            reg_sel_in;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_data;
    logic                  mem_we;
    logic [3:0]            reg_sel;
    logic [REG_WIDTH-1:0]  reg_data;
    logic                  reg_we;
    logic [REG_WIDTH-1:0]  sp_next;
    logic                  sp_we;
    logic                  busy;
    logic                  write_done;

    modport slave (
        input  write_req, write_mode, addr, data, pc, status, sp, reg_sel_in,
        output mem_addr, mem_data, mem_we, reg_sel, reg_data, reg_we,
               sp_next, sp_we, busy, write_done
    );

    modport master (
        output write_req, write_mode, addr, data, pc, status, sp, reg_sel_in,
        input  mem_addr, mem_data, mem_we, reg_sel, reg_data, reg_we,
               sp_next, sp_we, busy, write_done
    );
endinterface

// File: rtl/mem_writer.sv
// Sequencer for memory, register and stack-push writes, issuing one write beat per cycle.
// Every output is registered and is computed from the next state and the request being served.
module mem_writer #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
    input  logic         phi1,
    input  logic         reset,
    mem_writer_if.slave  bus
);
    localparam logic [2:0] M_MEM   = 3'd0;
    localparam logic [2:0] M_REG   = 3'd1;
    localparam logic [2:0] M_PUSH1 = 3'd2;
    localparam logic [2:0] M_PUSH2 = 3'd3;
    localparam logic [2:0] M_PUSH3 = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_BEAT1, S_BEAT2, S_BEAT3, S_FINISH} state_e;

    typedef struct packed {
        logic [2:0]            mode;
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  data;
        logic [ADDR_WIDTH-1:0] pc;
        logic [REG_WIDTH-1:0]  status;
        logic [REG_WIDTH-1:0]  sp;
        logic [3:0]            reg_sel;
    } req_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] mem_addr;
        logic [REG_WIDTH-1:0]  mem_data;
        logic                  mem_we;
        logic [3:0]            reg_sel;
        logic [REG_WIDTH-1:0]  reg_data;
        logic                  reg_we;
        logic [REG_WIDTH-1:0]  sp_next;
        logic                  sp_we;
        logic                  busy;
        logic                  write_done;
    } out_t;

    state_e state_q, state_d;
    req_t   req_q, req_d;
    out_t   out_q, out_d;
    logic   accept;

    // Stack offsets wrap inside REG_WIDTH bits so the address never leaves the stack page.
    function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [REG_WIDTH-1:0] sp_v,
                                                         input logic [REG_WIDTH-1:0] k);
        logic [REG_WIDTH-1:0] off;
        off = sp_v - k;
        return STACK_BASE + {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, off};
    endfunction

    assign accept = ((state_q == S_IDLE) || (state_q == S_FINISH)) && bus.write_req;

    // Beat-1 outputs are registered on the accept edge, so they must come from the live inputs.
    always_comb begin
        req_d = req_q;
        if (accept) begin
            req_d = '{mode: bus.write_mode, addr: bus.addr, data: bus.data, pc: bus.pc,
                      status: bus.status, sp: bus.sp, reg_sel: bus.reg_sel_in};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (bus.write_req) state_d = (bus.write_mode <= M_PUSH3) ? S_BEAT1 : S_FINISH;
                else               state_d = S_IDLE;
            end
            S_BEAT1: state_d = (req_q.mode == M_PUSH2 || req_q.mode == M_PUSH3) ? S_BEAT2 : S_FINISH;
            S_BEAT2: state_d = (req_q.mode == M_PUSH3) ? S_BEAT3 : S_FINISH;
            S_BEAT3: state_d = S_FINISH;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: out_d gets a full default first so no path through the case can infer a latch.
    always_comb begin
        out_d = '0;
        case (state_d)
            S_BEAT1: begin
                out_d.busy = 1'b1;
                case (req_d.mode)
                    M_MEM: begin
                        out_d.mem_we   = 1'b1;
                        out_d.mem_addr = req_d.addr;
                        out_d.mem_data = req_d.data;
                    end
                    M_REG: begin
                        out_d.reg_we   = 1'b1;
                        out_d.reg_sel  = req_d.reg_sel;
                        out_d.reg_data = req_d.data;
                    end
                    M_PUSH1: begin
                        out_d.mem_we   = 1'b1;
                        out_d.mem_addr = stack_addr(req_d.sp, REG_WIDTH'(0));
                        out_d.mem_data = req_d.data;
                        out_d.sp_we    = 1'b1;
                        out_d.sp_next  = req_d.sp - REG_WIDTH'(1);
                    end
                    default: begin
                        out_d.mem_we   = 1'b1;
                        out_d.mem_addr = stack_addr(req_d.sp, REG_WIDTH'(0));
                        out_d.mem_data = req_d.pc[ADDR_WIDTH-1 -: REG_WIDTH];
                    end
                endcase
            end
            S_BEAT2: begin
                out_d.busy     = 1'b1;
                out_d.mem_we   = 1'b1;
                out_d.mem_addr = stack_addr(req_d.sp, REG_WIDTH'(1));
                out_d.mem_data = req_d.pc[REG_WIDTH-1:0];
                if (req_d.mode == M_PUSH2) begin
                    out_d.sp_we   = 1'b1;
                    out_d.sp_next = req_d.sp - REG_WIDTH'(2);
                end
            end
            S_BEAT3: begin
                out_d.busy     = 1'b1;
                out_d.mem_we   = 1'b1;
                out_d.mem_addr = stack_addr(req_d.sp, REG_WIDTH'(2));
                out_d.mem_data = req_d.status;
                out_d.sp_we    = 1'b1;
                out_d.sp_next  = req_d.sp - REG_WIDTH'(3);
            end
            S_FINISH: out_d.write_done = 1'b1;
            default:  out_d = '0;
        endcase
    end

    assign bus.mem_addr   = out_q.mem_addr;
    assign bus.mem_data   = out_q.mem_data;
    assign bus.mem_we     = out_q.mem_we;
    assign bus.reg_sel    = out_q.reg_sel;
    assign bus.reg_data   = out_q.reg_data;
    assign bus.reg_we     = out_q.reg_we;
    assign bus.sp_next    = out_q.sp_next;
    assign bus.sp_we      = out_q.sp_we;
    assign bus.busy       = out_q.busy;
    assign bus.write_done = out_q.write_done;
endmodule

// File: tb/tb_mem_writer.sv
// Scoreboard bench for mem_writer: the stimulus pushes per-cycle expected outputs computed from a
// byte-list model of each operation, and a negedge monitor pops and compares them.
module tb_mem_writer;
    typedef struct packed {
        logic [15:0] mem_addr;
        logic [7:0]  mem_data;
        logic        mem_we;
        logic [3:0]  reg_sel;
        logic [7:0]  reg_data;
        logic        reg_we;
        logic [7:0]  sp_next;
        logic        sp_we;
        logic        busy;
        logic        write_done;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } ev_t;

    logic phi1 = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];

    mem_writer_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    mem_writer #(.REG_WIDTH(8), .ADDR_WIDTH(16), .STACK_BASE(16'h0100)) dut (
        .phi1  (phi1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 phi1 = ~phi1;
    always @(posedge phi1) cyc <= cyc + 1;

    function automatic out_t sample();
        out_t s;
        s = '{mem_addr: bus.mem_addr, mem_data: bus.mem_data, mem_we: bus.mem_we,
              reg_sel: bus.reg_sel, reg_data: bus.reg_data, reg_we: bus.reg_we,
              sp_next: bus.sp_next, sp_we: bus.sp_we, busy: bus.busy,
              write_done: bus.write_done};
        return s;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got we=%b a=%h d=%h rwe=%b rs=%h rd=%h swe=%b sn=%h busy=%b done=%b | exp we=%b a=%h d=%h rwe=%b rs=%h rd=%h swe=%b sn=%h busy=%b done=%b",
                     name, cyc, got.mem_we, got.mem_addr, got.mem_data, got.reg_we, got.reg_sel,
                     got.reg_data, got.sp_we, got.sp_next, got.busy, got.write_done,
                     exp.mem_we, exp.mem_addr, exp.mem_data, exp.reg_we, exp.reg_sel,
                     exp.reg_data, exp.sp_we, exp.sp_next, exp.busy, exp.write_done);
        end
    endtask

    // Monitor: expected events are keyed by cycle; any strobe with no event due is an error.
    always @(negedge phi1) begin
        out_t got;
        ev_t  ev;
        got = sample();
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            ev = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_event cyc=%0d expected at cyc=%0d", cyc, ev.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ev = exp_q.pop_front();
            check("beat", got, ev.o);
        end else if (got.mem_we || got.reg_we || got.sp_we || got.write_done || got.busy) begin
            check("unexpected_activity", got, '0);
        end
    end

    // Reference model: an operation is a list of bytes written to successive stack slots, or a
    // single memory/register write, followed by one completion cycle.
    task automatic push_expected(input int a_cyc, input int mode, input logic [15:0] addr,
                                 input logic [7:0] data, input logic [15:0] pc,
                                 input logic [7:0] status, input logic [7:0] sp,
                                 input logic [3:0] rsel, input int keep, output int n);
        ev_t         ev;
        logic [7:0]  vals[3];
        vals = '{pc[15:8], pc[7:0], status};
        n = 0;
        if (mode == 0 || mode == 1) n = 1;
        else if (mode >= 2 && mode <= 4) n = mode - 1;
        if (mode == 2) vals[0] = data;
        for (int i = 0; i < n && i < keep; i++) begin
            ev.cyc = a_cyc + i;
            ev.o   = '0;
            ev.o.busy = 1'b1;
            if (mode == 1) begin
                ev.o.reg_we = 1'b1; ev.o.reg_sel = rsel; ev.o.reg_data = data;
            end else if (mode == 0) begin
                ev.o.mem_we = 1'b1; ev.o.mem_addr = addr; ev.o.mem_data = data;
            end else begin
                ev.o.mem_we   = 1'b1;
                ev.o.mem_addr = 16'(32'h100 + ((int'(sp) - i + 256) % 256));
                ev.o.mem_data = vals[i];
                if (i == n - 1) begin
                    ev.o.sp_we   = 1'b1;
                    ev.o.sp_next = 8'((int'(sp) - n + 256) % 256);
                end
            end
            exp_q.push_back(ev);
        end
        if (keep > n) begin
            ev.cyc = a_cyc + n;
            ev.o   = '0;
            ev.o.write_done = 1'b1;
            exp_q.push_back(ev);
        end
    endtask

    task automatic junk_inputs();
        bus.write_req  = 1'($urandom_range(0, 1));
        bus.write_mode = 3'($urandom_range(0, 7));
        bus.addr       = 16'($urandom);
        bus.data       = 8'($urandom);
        bus.pc         = 16'($urandom);
        bus.status     = 8'($urandom);
        bus.sp         = 8'($urandom);
        bus.reg_sel_in = 4'($urandom);
    endtask

    // Called at a negedge; returns at the negedge of the FINISH cycle with write_req still driven.
    task automatic issue(input int mode, input logic [15:0] addr, input logic [7:0] data,
                         input logic [15:0] pc, input logic [7:0] status, input logic [7:0] sp,
                         input logic [3:0] rsel);
        int n;
        bus.write_req  = 1'b1;
        bus.write_mode = 3'(mode);
        bus.addr = addr; bus.data = data; bus.pc = pc;
        bus.status = status; bus.sp = sp; bus.reg_sel_in = rsel;
        push_expected(cyc + 1, mode, addr, data, pc, status, sp, rsel, 4, n);
        for (int i = 0; i <= n; i++) begin
            @(negedge phi1);
            if (i < n) junk_inputs();
        end
    endtask

    task automatic idle(input int k);
        bus.write_req = 1'b0;
        repeat (k) @(negedge phi1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.write_req = 1'b0; bus.write_mode = '0; bus.addr = '0; bus.data = '0;
        bus.pc = '0; bus.status = '0; bus.sp = '0; bus.reg_sel_in = '0;
        repeat (3) @(negedge phi1);
        check("reset_state", sample(), '0);
        reset = 1'b0;
        @(negedge phi1);
        check("idle_after_reset", sample(), '0);

        issue(0, 16'h0234, 8'h5A, 16'h0, 8'h0, 8'h0, 4'h0);
        idle(1);
        issue(3, 16'h0, 8'h0, 16'hC012, 8'h0, 8'hFD, 4'h0);
        issue(4, 16'h0, 8'h0, 16'h8000, 8'h34, 8'h01, 4'h0);
        issue(1, 16'h0, 8'h7F, 16'h0, 8'h0, 8'h0, 4'h2);
        issue(2, 16'h0, 8'hA5, 16'h0, 8'h0, 8'h00, 4'h0);
        issue(6, 16'h0, 8'h0, 16'h0, 8'h0, 8'h0, 4'h0);
        idle(2);

        // PUSH3 abandoned by reset during beat 2, with write_req held high throughout.
        bus.write_req = 1'b1; bus.write_mode = 3'd4; bus.pc = 16'h1234;
        bus.status = 8'h56; bus.sp = 8'h80;
        push_expected(cyc + 1, 4, 16'h0, 8'h0, 16'h1234, 8'h56, 8'h80, 4'h0, 2, n);
        @(negedge phi1);
        junk_inputs(); bus.write_req = 1'b1;
        @(negedge phi1);
        reset = 1'b1; bus.write_req = 1'b1; bus.write_mode = 3'd0;
        repeat (2) begin
            @(negedge phi1);
            check("reset_abandon", sample(), '0);
        end
        reset = 1'b0; bus.write_req = 1'b0;
        repeat (2) begin
            @(negedge phi1);
            check("post_reset_idle", sample(), '0);
        end

        for (int t = 0; t < 300; t++) begin
            issue(int'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), 16'($urandom),
                  8'($urandom), 8'($urandom), 4'($urandom));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending events, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, data/register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 SHALL have parameter STACK_BASE, default 16'h0100, stack page base address.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 phi1  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 write_req  input  1  request strobe, sampled only in IDLE.
REQ-008 write_mode  input  3  0=MEM, 1=REG, 2=PUSH1, 3=PUSH2, 4=PUSH3, 5-7 reserved.
REQ-009 addr  input  ADDR_WIDTH  target address for MEM mode.
REQ-010 data  input  REG_WIDTH  byte for MEM, REG and PUSH1.
REQ-011 pc  input  ADDR_WIDTH  return address for PUSH2/PUSH3.
REQ-012 status  input  REG_WIDTH  status byte, third beat of PUSH3.
REQ-013 sp  input  REG_WIDTH  current stack pointer.
REQ-014 reg_sel_in  input  4  destination register selector for REG mode.
REQ-015 mem_addr  output  ADDR_WIDTH  write address.
REQ-016 mem_data  output  REG_WIDTH  write data.
REQ-017 mem_we  output  1  memory write enable, one cycle per beat.
REQ-018 reg_sel, reg_data, reg_we  output  4/REG_WIDTH/1  register write port.
REQ-019 sp_next, sp_we  output  REG_WIDTH/1  updated stack pointer and its one-cycle strobe.
REQ-020 busy, write_done  output  1/1  operation in progress; one-cycle completion pulse.

Function
REQ-021 States SHALL be IDLE, BEAT1, BEAT2, BEAT3, FINISH; all outputs registered.
REQ-022 On an edge in IDLE with write_req=1, block SHALL latch all inputs, set busy=1, enter BEAT1, and present beat-1 outputs in the following cycle.
REQ-023 write_req outside IDLE SHALL be ignored and not queued.
REQ-024 MEM: one beat, mem_addr=addr, mem_data=data, mem_we=1; no sp_we.
REQ-025 REG: one beat, reg_we=1, reg_sel=reg_sel_in, reg_data=data; mem_we stays 0.
REQ-026 PUSH1: one beat at STACK_BASE+sp with data; sp_next=sp-1.
REQ-027 PUSH2: beats pc[15:8] at STACK_BASE+sp, then pc[7:0] at STACK_BASE+sp-1; sp_next=sp-2.
REQ-028 PUSH3: PUSH2 beats, then status at STACK_BASE+sp-2; sp_next=sp-3.
REQ-029 Stack offset arithmetic SHALL be 8-bit modulo 256; addresses never leave the stack page (sp=00 -> 01FF next).
REQ-030 sp_we and sp_next SHALL be asserted together in the cycle of the final beat only.
REQ-031 Reserved modes: no write strobes; FINISH next cycle.
REQ-032 FINISH: mem_we, reg_we, sp_we=0; write_done=1 and busy=0 for exactly one cycle; return to IDLE.
REQ-033 A new request SHALL be acceptable on the edge ending the FINISH cycle; latency MEM/REG/PUSH1 = 2 cycles accept-to-done, PUSH2 = 3, PUSH3 = 4.
REQ-034 Between beats mem_we SHALL stay high each beat cycle with address/data changing per beat (no idle gaps).

Reset
REQ-035 On reset, next edge: state IDLE; mem_addr, mem_data, reg_sel, reg_data, sp_next = 0; mem_we, reg_we, sp_we, busy, write_done = 0.
REQ-036 Reset mid-operation SHALL abandon remaining beats, suppress sp_we and write_done, and take priority over write_req on the same edge.

Verification
REQ-037 MEM: mode 0, addr=0x0234, data=0x5A -> next cycle mem_we=1, mem_addr=0x0234, mem_data=0x5A; following cycle write_done=1.
REQ-038 PUSH2: pc=0xC012, sp=0xFD -> beats (0x01FD,0xC0),(0x01FC,0x12); sp_we=1, sp_next=0xFB on beat 2; done 3 cycles after accept.
REQ-039 PUSH3 wrap: sp=0x01, pc=0x8000, status=0x34 -> (0x0101,0x80),(0x0100,0x00),(0x01FF,0x34); sp_next=0xFE.
REQ-040 REG: mode 1, reg_sel_in=2, data=0x7F -> reg_we=1, reg_sel=2, reg_data=0x7F one cycle; mem_we never 1.
REQ-041 Reset during PUSH3 beat 2 -> no beat 3, no sp_we, no write_done, all outputs 0; write_req held during busy ignored.
